// File: rtl/counter_cycle_arbiter.sv
// -----------------------------------------------------------------------------
// counter_cycle_arbiter
//
// Keeps the 12-step memory-cycle time-pulse count (TP 1..12) and, when the
// instruction sequencer allows it, steals one memory cycle to service a
// counter-cell increment request. During a stolen cycle it drives the
// read/write/clear strobes and the PINC/MINC increment strobes to the
// service-gate decoder.
//
// Ports:
//   SIM_CLK         clock, one time pulse per rising edge
//   SIM_RST         asynchronous active-low reset (release synchronized)
//   CNTREQ[NREQ]    level increment requests, held until acknowledged
//   CNTDIR[NREQ]    per-request direction, 0 = plus, 1 = minus
//   ST_ALLOW        stolen cycle permitted, sampled at TP12 only
//   GOJAM_n         synchronous abort, active-low
//   TP[4]           current time pulse, 1..12
//   STEAL           high for all 12 pulses of a stolen cycle
//   CADDR           granted counter index, held through the stolen cycle
//   CNTACK[NREQ]    one-hot, one-clock acknowledge at TP12
//   RT_n RSC_n WG_n WT_n WSC_n CT_n PINC_n MINC_n  active-low strobes
//
// Build option:
//   CNT_ROUNDROBIN_EN  rotating priority starting after the last acknowledged
//                      index; otherwise fixed priority, lowest index first.
// -----------------------------------------------------------------------------
module counter_cycle_arbiter #(
  parameter  int NREQ = 8,
  localparam int AW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            SIM_CLK,
  input  logic            SIM_RST,
  input  logic [NREQ-1:0] CNTREQ,
  input  logic [NREQ-1:0] CNTDIR,
  input  logic            ST_ALLOW,
  input  logic            GOJAM_n,
  output logic [3:0]      TP,
  output logic            STEAL,
  output logic [AW-1:0]   CADDR,
  output logic [NREQ-1:0] CNTACK,
  output logic            RT_n,
  output logic            RSC_n,
  output logic            WG_n,
  output logic            WT_n,
  output logic            WSC_n,
  output logic            CT_n,
  output logic            PINC_n,
  output logic            MINC_n
);

  localparam logic [3:0] TP_FIRST = 4'd1;
  localparam logic [3:0] TP_LAST  = 4'd12;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_STEAL = 1'b1
  } state_t;

  // Active-low strobe bundle; all ones means nothing asserted.
  typedef struct packed {
    logic rt;
    logic rsc;
    logic wg;
    logic wt;
    logic wsc;
    logic ct;
    logic pinc;
    logic minc;
  } strobe_t;

  // Reset synchronizer: assertion is immediate, release waits two edges.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  logic [3:0]      tp_q,     tp_d;
  state_t          state_q,  state_d;
  logic [AW-1:0]   caddr_q,  caddr_d;
  logic            dir_q,    dir_d;
  logic [NREQ-1:0] cntack_q, cntack_d;
  strobe_t         strb_q,   strb_d;
  logic            steal_d;

  logic [NREQ-1:0] req_masked;
  logic            grant_found;
  logic [AW-1:0]   grant_idx;

  // A requester being acknowledged this clock may still hold its request
  // line; it must not win again on the same edge.
  assign req_masked = CNTREQ & ~cntack_q;

`ifdef CNT_ROUNDROBIN_EN
  logic [AW-1:0] rr_ptr_q, rr_ptr_d;
`endif

  // Priority search over the masked requests.
  always_comb begin : arb_search
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef CNT_ROUNDROBIN_EN
      idx = (int'(rr_ptr_q) + k) % NREQ;
`else
      idx = k;
`endif
      if (!grant_found && req_masked[idx]) begin
        grant_found = 1'b1;
        grant_idx   = AW'(idx);
      end
    end
  end

  // Next-state and registered-output decode. Strobes are decoded from the
  // next TP/state so they change on the same edge as TP with no glitch.
  always_comb begin
    // NOTE: every *_d takes a default before any condition, so no path can
    // leave one unassigned and infer a latch.
    tp_d     = (tp_q == TP_LAST) ? TP_FIRST : tp_q + 4'd1;
    state_d  = state_q;
    caddr_d  = caddr_q;
    dir_d    = dir_q;
    strb_d   = '1;
    cntack_d = '0;

    if (tp_q == TP_LAST) begin
      if (ST_ALLOW && grant_found) begin
        state_d = S_STEAL;
        caddr_d = grant_idx;
        dir_d   = CNTDIR[grant_idx];
      end else begin
        state_d = S_IDLE;
      end
    end

    // Abort wins over the TP12 decision; the aborted grant is never acked.
    if (!GOJAM_n) begin
      tp_d    = TP_FIRST;
      state_d = S_IDLE;
      caddr_d = caddr_q;
      dir_d   = dir_q;
    end

    steal_d = (state_d == S_STEAL);

    if (steal_d) begin
      unique case (tp_d)
        4'd2: begin
          strb_d.rt  = 1'b0;
          strb_d.rsc = 1'b0;
        end
        4'd5: begin
          if (dir_d) strb_d.minc = 1'b0;
          else       strb_d.pinc = 1'b0;
        end
        4'd8: begin
          strb_d.wt  = 1'b0;
          strb_d.wg  = 1'b0;
          strb_d.wsc = 1'b0;
        end
        4'd11: strb_d.ct = 1'b0;
        4'd12: cntack_d = {{(NREQ-1){1'b0}}, 1'b1} << caddr_d;
        default: ;
      endcase
    end
  end

`ifdef CNT_ROUNDROBIN_EN
  // Pointer moves past the acknowledged index as the ack is issued.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (cntack_d != '0) begin
      rr_ptr_d = (caddr_d == AW'(NREQ - 1)) ? '0 : caddr_d + AW'(1);
    end
  end

  always_ff @(posedge SIM_CLK or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_ff @(posedge SIM_CLK or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      tp_q     <= TP_FIRST;
      state_q  <= S_IDLE;
      caddr_q  <= '0;
      dir_q    <= 1'b0;
      cntack_q <= '0;
      strb_q   <= '1;
    end else begin
      tp_q     <= tp_d;
      state_q  <= state_d;
      caddr_q  <= caddr_d;
      dir_q    <= dir_d;
      cntack_q <= cntack_d;
      strb_q   <= strb_d;
    end
  end

  assign TP     = tp_q;
  assign STEAL  = (state_q == S_STEAL);
  assign CADDR  = caddr_q;
  assign CNTACK = cntack_q;
  assign RT_n   = strb_q.rt;
  assign RSC_n  = strb_q.rsc;
  assign WG_n   = strb_q.wg;
  assign WT_n   = strb_q.wt;
  assign WSC_n  = strb_q.wsc;
  assign CT_n   = strb_q.ct;
  assign PINC_n = strb_q.pinc;
  assign MINC_n = strb_q.minc;

endmodule

// File: tb/tb_counter_cycle_arbiter.sv
// -----------------------------------------------------------------------------
// tb_counter_cycle_arbiter
//
// Directed stimulus pushes the expected grant (index, direction) of every
// stolen cycle that must complete into a queue; a monitor logs the TP at
// which each strobe asserts and, whenever CNTACK fires, pops the queue and
// compares the ack vector, CADDR and the strobe timing.
// -----------------------------------------------------------------------------
module tb_counter_cycle_arbiter;

  localparam int NREQ = 8;

  logic       SIM_CLK;
  logic       SIM_RST;
  logic [7:0] CNTREQ;
  logic [7:0] CNTDIR;
  logic       ST_ALLOW;
  logic       GOJAM_n;
  logic [3:0] TP;
  logic       STEAL;
  logic [2:0] CADDR;
  logic [7:0] CNTACK;
  logic       RT_n, RSC_n, WG_n, WT_n, WSC_n, CT_n, PINC_n, MINC_n;
  logic [7:0] strobes;

  counter_cycle_arbiter #(.NREQ(NREQ)) dut (
    .SIM_CLK  (SIM_CLK),
    .SIM_RST  (SIM_RST),
    .CNTREQ   (CNTREQ),
    .CNTDIR   (CNTDIR),
    .ST_ALLOW (ST_ALLOW),
    .GOJAM_n  (GOJAM_n),
    .TP       (TP),
    .STEAL    (STEAL),
    .CADDR    (CADDR),
    .CNTACK   (CNTACK),
    .RT_n     (RT_n),
    .RSC_n    (RSC_n),
    .WG_n     (WG_n),
    .WT_n     (WT_n),
    .WSC_n    (WSC_n),
    .CT_n     (CT_n),
    .PINC_n   (PINC_n),
    .MINC_n   (MINC_n)
  );

  // Bit order: 7 rt, 6 rsc, 5 wg, 4 wt, 3 wsc, 2 ct, 1 pinc, 0 minc.
  assign strobes = {RT_n, RSC_n, WG_n, WT_n, WSC_n, CT_n, PINC_n, MINC_n};

  initial SIM_CLK = 1'b0;
  always #5 SIM_CLK = ~SIM_CLK;

  typedef struct {
    logic [2:0] caddr;
    logic       dir;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   stray  = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // One clock; the requester model drops any request that was just acked.
  task automatic tick();
    @(negedge SIM_CLK);
    if (CNTACK != 8'h00) CNTREQ = CNTREQ & ~CNTACK;
  endtask

  // Advance at least one clock, then until TP equals n (bounded).
  task automatic goto_tp(input int n);
    int guard;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (int'(TP) != n && guard < 40);
    if (int'(TP) != n) check("goto_tp_timeout", int'(TP), n);
  endtask

  task automatic push_exp(input logic [2:0] caddr, input logic dir);
    exp_t e;
    e.caddr = caddr;
    e.dir   = dir;
    exp_q.push_back(e);
  endtask

  // Monitor / scoreboard.
  initial begin : monitor
    int    obs_tp [8];
    int    exp_tp [8];
    string names  [8];
    exp_t  e;
    logic [7:0] ack_exp;
    names = '{"minc", "pinc", "ct", "wsc", "wt", "wg", "rsc", "rt"};
    foreach (obs_tp[i]) obs_tp[i] = 0;
    forever begin
      @(negedge SIM_CLK);
      if (!SIM_RST) begin
        foreach (obs_tp[i]) obs_tp[i] = 0;
      end else begin
        if (STEAL && TP == 4'd1) foreach (obs_tp[i]) obs_tp[i] = 0;
        if (STEAL) begin
          for (int i = 0; i < 8; i++)
            if (!strobes[i]) obs_tp[i] = (obs_tp[i] == 0) ? int'(TP) : 99;
        end else if (strobes != 8'hFF || CNTACK != 8'h00) begin
          stray++;
        end
        if (CNTACK != 8'h00) begin
          if (exp_q.size() == 0) begin
            check("unexpected_ack", int'(CNTACK), 0);
          end else begin
            e       = exp_q.pop_front();
            ack_exp = 8'h01 << e.caddr;
            exp_tp  = '{(e.dir ? 5 : 0), (e.dir ? 0 : 5), 11, 8, 8, 8, 2, 2};
            check("ack_vec", int'(CNTACK), int'(ack_exp));
            check("ack_caddr", int'(CADDR), int'(e.caddr));
            for (int i = 0; i < 8; i++)
              check({"strobe_tp_", names[i]}, obs_tp[i], exp_tp[i]);
          end
        end
      end
    end
  end

  // Global time limit.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int guard;
    int first_idx, second_idx;
    CNTREQ   = 8'h00;
    CNTDIR   = 8'h00;
    ST_ALLOW = 1'b0;
    GOJAM_n  = 1'b1;
    SIM_RST  = 1'b1;
    #2 SIM_RST = 1'b0;

    // Reset values.
    repeat (3) @(negedge SIM_CLK);
    check("rst_tp", int'(TP), 1);
    check("rst_steal", int'(STEAL), 0);
    check("rst_caddr", int'(CADDR), 0);
    check("rst_cntack", int'(CNTACK), 0);
    check("rst_strobes", int'(strobes), 8'hFF);
    SIM_RST = 1'b1;
    goto_tp(12);
    tick();
    check("tp_wrap", int'(TP), 1);

    // Single request, plus direction; direction change after grant ignored.
    CNTREQ   = 8'h04;
    CNTDIR   = 8'h00;
    ST_ALLOW = 1'b1;
    push_exp(3'd2, 1'b0);
    goto_tp(12);
    tick();
    check("single_steal", int'(STEAL), 1);
    check("single_caddr", int'(CADDR), 2);
    CNTDIR = 8'hFF;
    goto_tp(12);
    tick();
    check("single_end", int'(STEAL), 0);
    CNTDIR = 8'h00;

    // ST_ALLOW gating: two TP12 boundaries without permission.
    ST_ALLOW = 1'b0;
    CNTREQ   = 8'h01;
    for (int c = 0; c < 2; c++) begin
      goto_tp(12);
      tick();
      check("gate_no_steal", int'(STEAL), 0);
    end
    ST_ALLOW = 1'b1;
    push_exp(3'd0, 1'b0);
    goto_tp(12);
    tick();
    check("gate_steal", int'(STEAL), 1);
    check("gate_caddr", int'(CADDR), 0);
    goto_tp(12);
    tick();
    check("gate_end", int'(STEAL), 0);

    // Contention: bits 0 and 7, bit 7 counts down. Last grant was 0.
`ifdef CNT_ROUNDROBIN_EN
    first_idx  = 7;
    second_idx = 0;
    push_exp(3'd7, 1'b1);
    push_exp(3'd0, 1'b0);
`else
    first_idx  = 0;
    second_idx = 7;
    push_exp(3'd0, 1'b0);
    push_exp(3'd7, 1'b1);
`endif
    CNTREQ = 8'h81;
    CNTDIR = 8'h80;
    goto_tp(12);
    tick();
    check("cont_first_steal", int'(STEAL), 1);
    check("cont_first_caddr", int'(CADDR), first_idx);
    goto_tp(12);
    tick();
    check("cont_b2b_steal", int'(STEAL), 1);
    check("cont_second_caddr", int'(CADDR), second_idx);
    goto_tp(12);
    tick();
    check("cont_end", int'(STEAL), 0);
    CNTDIR = 8'h00;

    // Abort at TP9 of a minus cycle; the request is regranted later.
    CNTREQ = 8'h10;
    CNTDIR = 8'h10;
    goto_tp(12);
    tick();
    check("abort_steal", int'(STEAL), 1);
    check("abort_caddr", int'(CADDR), 4);
    goto_tp(5);
    check("abort_minc_tp5", int'(MINC_n), 0);
    check("abort_pinc_tp5", int'(PINC_n), 1);
    goto_tp(9);
    GOJAM_n = 1'b0;
    tick();
    GOJAM_n = 1'b1;
    check("abort_tp", int'(TP), 1);
    check("abort_steal_off", int'(STEAL), 0);
    check("abort_ct", int'(CT_n), 1);
    check("abort_no_ack", int'(CNTACK), 0);
    check("abort_req_pending", int'(CNTREQ), 8'h10);
    push_exp(3'd4, 1'b1);
    goto_tp(12);
    tick();
    check("regrant_steal", int'(STEAL), 1);
    check("regrant_caddr", int'(CADDR), 4);
    goto_tp(12);
    tick();
    check("regrant_end", int'(STEAL), 0);
    CNTDIR = 8'h00;

    // Reset asserted at TP6 of a stolen cycle.
    CNTREQ = 8'h02;
    goto_tp(12);
    tick();
    check("midrst_steal", int'(STEAL), 1);
    goto_tp(6);
    #2;
    SIM_RST  = 1'b0;
    CNTREQ   = 8'h00;
    ST_ALLOW = 1'b0;
    #1;
    check("midrst_tp", int'(TP), 1);
    check("midrst_steal_off", int'(STEAL), 0);
    check("midrst_caddr", int'(CADDR), 0);
    check("midrst_cntack", int'(CNTACK), 0);
    check("midrst_strobes", int'(strobes), 8'hFF);
    tick();
    SIM_RST = 1'b1;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (TP == 4'd1 && guard < 10);
    for (int k = 2; k <= 12; k++) begin
      check("post_rst_tp", int'(TP), k);
      tick();
    end
    check("post_rst_wrap", int'(TP), 1);

    tick();
    check("sb_empty", exp_q.size(), 0);
    check("stray_strobes", stray, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
